// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle between the pipeline datapath and the controller.
// master = datapath side (hazard info in), slave = controller (EN/CLR out).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [4:0]       in_id_rs;
    logic [4:0]       in_id_rt;
    logic             in_id_use_rs;
    logic             in_id_use_rt;
    logic             in_ex_memread;
    logic [4:0]       in_ex_rw;
    logic             in_ex_redirect;
    logic             in_halt;
    logic             in_go;
    logic             in_irq;
    logic             out_pc_en;
    logic             out_ifid_en;
    logic             out_idex_en;
    logic             out_exmem_en;
    logic             out_memwb_en;
    logic             out_ifid_clr;
    logic             out_idex_clr;
    logic             out_vec_load;
    logic             out_irq_ack;
    logic [1:0]       out_state;
    logic [CNT_W-1:0] out_stall_cnt;
    logic [CNT_W-1:0] out_flush_cnt;

    modport master (
        output in_id_rs, in_id_rt, in_id_use_rs, in_id_use_rt,
        output in_ex_memread, in_ex_rw, in_ex_redirect,
        output in_halt, in_go, in_irq,
        input  out_pc_en, out_ifid_en, out_idex_en,
        input  out_exmem_en, out_memwb_en,
        input  out_ifid_clr, out_idex_clr,
        input  out_vec_load, out_irq_ack, out_state,
        input  out_stall_cnt, out_flush_cnt
    );

    modport slave (
        input  in_id_rs, in_id_rt, in_id_use_rs, in_id_use_rt,
        input  in_ex_memread, in_ex_rw, in_ex_redirect,
        input  in_halt, in_go, in_irq,
        output out_pc_en, out_ifid_en, out_idex_en,
        output out_exmem_en, out_memwb_en,
        output out_ifid_clr, out_idex_clr,
        output out_vec_load, out_irq_ack, out_state,
        output out_stall_cnt, out_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard/sequencing controller: load-use, flush, halt, irq drain.
// Optional statistics counters enabled by defining PIPE_HAZARD_STAT_EN.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input logic               in_CLK,
    input logic               in_RST_N,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [2:0] drain_cnt;
    logic       load_use;
    logic       rs_hit;
    logic       rt_hit;

    assign rs_hit   = bus.in_id_use_rs && (bus.in_id_rs == bus.in_ex_rw);
    assign rt_hit   = bus.in_id_use_rt && (bus.in_id_rt == bus.in_ex_rw);
    assign load_use = bus.in_ex_memread && (bus.in_ex_rw != 5'd0)
                   && (rs_hit || rt_hit);

    // Enables/clears are combinational from state and the current inputs
    always_comb begin
        bus.out_pc_en    = 1'b1;
        bus.out_ifid_en  = 1'b1;
        bus.out_idex_en  = 1'b1;
        bus.out_exmem_en = 1'b1;
        bus.out_memwb_en = 1'b1;
        bus.out_ifid_clr = 1'b0;
        bus.out_idex_clr = 1'b0;
        bus.out_vec_load = 1'b0;
        bus.out_irq_ack  = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.in_halt) begin
                    bus.out_pc_en = 1'b1;
                end else if (bus.in_ex_redirect) begin
                    bus.out_ifid_clr = 1'b1;
                    bus.out_idex_clr = 1'b1;
                end else if (bus.in_irq) begin
                    bus.out_pc_en    = 1'b0;
                    bus.out_ifid_clr = 1'b1;
                end else if (load_use) begin
                    bus.out_pc_en    = 1'b0;
                    bus.out_ifid_en  = 1'b0;
                    bus.out_idex_clr = 1'b1;
                end
            end
            HALT: begin
                bus.out_pc_en    = 1'b0;
                bus.out_ifid_en  = 1'b0;
                bus.out_idex_en  = 1'b0;
                bus.out_exmem_en = 1'b0;
                bus.out_memwb_en = 1'b0;
            end
            DRAIN: begin
                bus.out_pc_en    = 1'b0;
                bus.out_ifid_clr = 1'b1;
                bus.out_idex_clr = bus.in_ex_redirect;
            end
            ACK: begin
                bus.out_pc_en    = 1'b1;
                bus.out_ifid_clr = 1'b1;
                bus.out_vec_load = 1'b1;
                bus.out_irq_ack  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencing FSM: halt/resume and interrupt drain countdown
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.in_halt) begin
                        state <= HALT;
                    end else if (!bus.in_ex_redirect && bus.in_irq) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                HALT: begin
                    if (bus.in_go) state <= RUN;
                end
                DRAIN: begin
                    if (drain_cnt == 3'd0) state <= ACK;
                    else drain_cnt <= drain_cnt - 3'd1;
                end
                ACK: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.out_state = state;

`ifdef PIPE_HAZARD_STAT_EN
    logic             run_ok;
    logic             stall_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign run_ok    = (state == RUN) && !bus.in_halt;
    assign flush_evt = run_ok && bus.in_ex_redirect;
    assign stall_evt = run_ok && !bus.in_ex_redirect
                    && !bus.in_irq && load_use;

    // Saturating event counters; they stick at all-ones
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.out_stall_cnt = stall_cnt;
    assign bus.out_flush_cnt = flush_cnt;
`else
    assign bus.out_stall_cnt = '0;
    assign bus.out_flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage CPU. It drives the enable and clear inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use stalls and taken-branch flushes, and runs halt and interrupt-drain sequencing. It is the control end of the pipeline-register interface: every pipeline register's EN/CLR comes from this block.

## Interface
Parameters:
- DRAIN_CYCLES, 3: bubble cycles inserted before interrupt acknowledge (1..7).
- CNT_W, 16: width of statistics counters.

Ports:
- in_CLK  input  1  clock; all state updates on the rising edge.
- in_RST_N  input  1  reset, asynchronous, active-low.
- in_id_rs, in_id_rt  input  5 each  source register numbers of the instruction in ID.
- in_id_use_rs, in_id_use_rt  input  1 each  ID instruction actually reads rs/rt.
- in_ex_memread  input  1  instruction in EX is a load.
- in_ex_rw  input  5  destination register of the EX instruction.
- in_ex_redirect  input  1  taken branch or jump resolved in EX.
- in_halt  input  1  halt instruction in EX.
- in_go  input  1  resume pulse, used in HALT only.
- in_irq  input  1  level interrupt request.
- out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en  output  1 each  register enables.
- out_ifid_clr, out_idex_clr  output  1 each  synchronous-use clears; asserted for exactly the cycles bubbles are required.
- out_vec_load  output  1  PC loads the interrupt vector this cycle.
- out_irq_ack  output  1  interrupt acknowledge, one-cycle pulse.
- out_state  output  2  RUN=0, HALT=1, DRAIN=2, ACK=3.
- out_stall_cnt, out_flush_cnt  output  CNT_W each  statistics counters.

## Operation
- States: RUN, HALT, DRAIN, ACK. Reset value is RUN, with the drain counter and both statistics counters at 0.
- RUN, priority from highest to lowest:
  1. in_halt=1: go to HALT. This cycle, all enables are 1 and clears are 0, so the halt instruction advances.
  2. in_ex_redirect=1: out_ifid_clr=1, out_idex_clr=1, all enables 1. Flush counter increments. A coincident load-use condition is ignored.
  3. in_irq=1: go to DRAIN and load the drain counter with DRAIN_CYCLES-1. This cycle, out_pc_en=0 and out_ifid_clr=1.
  4. Load-use hazard: in_ex_memread=1, in_ex_rw!=0, and either (in_id_use_rs and in_id_rs==in_ex_rw) or (in_id_use_rt and in_id_rt==in_ex_rw). Response: out_pc_en=0, out_ifid_en=0, out_idex_clr=1, remaining enables 1. Stall counter increments.
  5. Otherwise: all enables 1, all clears 0.
- HALT: all five enables 0 and clears 0. in_go=1 returns to RUN on the next edge. in_irq is ignored while in HALT.
- DRAIN: out_pc_en=0 and out_ifid_clr=1. ID/EX, EX/MEM and MEM/WB enabled so older instructions retire. The counter decrements each cycle; at 0 the next state is ACK. A redirect during DRAIN asserts out_idex_clr and does not change the count.
- ACK: one cycle. out_irq_ack=1, out_vec_load=1, out_pc_en=1, out_ifid_clr=1. Next state is RUN.
- Statistics counters saturate at all-ones and never wrap.
- Register 0 never causes a stall.

## Timing
- All enable, clear, out_vec_load and out_irq_ack outputs are combinational from the current state and inputs, valid in the same cycle.
- out_state and the counters are registered and change on the rising edge.
- Interrupt latency from in_irq sampled in RUN to out_irq_ack: DRAIN_CYCLES+1 cycles.
- Load-use inserts exactly one bubble, because the hazard clears once the load moves to MEM.
- Async reset mid-sequence (DRAIN/ACK/HALT) returns immediately to RUN with counters 0. In RUN with no hazard, the outputs during reset are all enables 1 and clears 0.

## Configuration
- PIPE_HAZARD_STAT_EN defined: out_stall_cnt and out_flush_cnt count as specified.
- PIPE_HAZARD_STAT_EN undefined: counter registers are removed and both outputs are tied to 0. Hazard behaviour is unchanged.

## Test plan
- Load-use: ex_memread=1, ex_rw=5, id_rs=5, use_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_clr=1; next cycle all enables 1; stall_cnt=1.
- Load to r0: ex_rw=0, id_rs=0 -> no stall; stall_cnt stays 0.
- Redirect concurrent with load-use -> ifid_clr=1, idex_clr=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- irq=1 in RUN with DRAIN_CYCLES=3 -> state 2 for 3 cycles with pc_en=0, then state 3 with irq_ack=vec_load=1 for 1 cycle, then state 0.
- halt=1 -> state 1, all enables 0; irq=1 ignored; go=1 -> state 0 next edge.
- Reset asserted during DRAIN -> state 0 immediately, counters 0. Force stall_cnt to 0xFFFF -> a further stall holds it at 0xFFFF.
